// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the EX-stage ALU control unit.
// ALU operation codes, R-type func values, main-decoder classes and FSM states.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd4;
    localparam logic [3:0] ALU_OR  = 4'd5;
    localparam logic [3:0] ALU_XOR = 4'd6;
    localparam logic [3:0] ALU_NOR = 4'd7;
    localparam logic [3:0] ALU_SLT = 4'd8;
    localparam logic [3:0] ALU_SLL = 4'd9;
    localparam logic [3:0] ALU_SRL = 4'd10;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;

    localparam logic [1:0] OP_ADD     = 2'd0;
    localparam logic [1:0] OP_SUB     = 2'd1;
    localparam logic [1:0] OP_RTYPE   = 2'd2;
    localparam logic [1:0] OP_ADD_ALT = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_ctrl_seq_decode.sv
// Combinational alu_op/func decoder for the ALU control unit.
// DIV is only recognised when ALU_CTRL_DIV_EN is defined; otherwise it decodes as unknown.
module alu_func_decode
    import alu_ctrl_pkg::*;
#(
    parameter int FUNC_W = 6,
    parameter int CTRL_W = 4
) (
    input  logic [1:0]        alu_op,
    input  logic [FUNC_W-1:0] func,
    output logic [CTRL_W-1:0] code,
    output logic              is_mul,
    output logic              is_div,
    output logic              illegal
);

    // Map main-decoder class and R-type func to an ALU code and MDU flags
    always_comb begin
        code    = CTRL_W'(ALU_ADD);
        is_mul  = 1'b0;
        is_div  = 1'b0;
        illegal = 1'b0;
        case (alu_op)
            OP_ADD, OP_ADD_ALT: code = CTRL_W'(ALU_ADD);
            OP_SUB:             code = CTRL_W'(ALU_SUB);
            OP_RTYPE: begin
                case (func)
                    FUNC_W'(F_ADD):  code   = CTRL_W'(ALU_ADD);
                    FUNC_W'(F_SUB):  code   = CTRL_W'(ALU_SUB);
                    FUNC_W'(F_AND):  code   = CTRL_W'(ALU_AND);
                    FUNC_W'(F_OR):   code   = CTRL_W'(ALU_OR);
                    FUNC_W'(F_XOR):  code   = CTRL_W'(ALU_XOR);
                    FUNC_W'(F_NOR):  code   = CTRL_W'(ALU_NOR);
                    FUNC_W'(F_SLT):  code   = CTRL_W'(ALU_SLT);
                    FUNC_W'(F_SLL):  code   = CTRL_W'(ALU_SLL);
                    FUNC_W'(F_SRL):  code   = CTRL_W'(ALU_SRL);
                    FUNC_W'(F_MULT): is_mul = 1'b1;
`ifdef ALU_CTRL_DIV_EN
                    FUNC_W'(F_DIV):  is_div = 1'b1;
`else
                    FUNC_W'(F_DIV):  illegal = 1'b1;
`endif
                    default:         illegal = 1'b1;
                endcase
            end
            default: code = CTRL_W'(ALU_ADD);
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// EX-stage ALU control unit: registered control word plus MULT/DIV busy sequencer.
// Define ALU_CTRL_DIV_EN to decode and sequence DIV; otherwise DIV decodes as unknown.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int FUNC_W  = 6,
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [1:0]        alu_op,
    input  logic [FUNC_W-1:0] func,
    input  logic              flush,
    output logic [CTRL_W-1:0] alu_control,
    output logic              ctrl_valid,
    output logic              illegal,
    output logic              mdu_start,
    output logic              mdu_div,
    output logic              stall,
    output logic              hilo_we
);

    state_e            state_r, state_nx_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nx_s, cnt_init_s;
    logic [CTRL_W-1:0] dec_code_s, code_r, code_nx_s;
    logic              dec_mul_s, dec_div_s, dec_ill_s, mdu_op_s;
    logic              cv_r, cv_nx_s;
    logic              ill_r, ill_nx_s;
    logic              start_r, start_nx_s;
    logic              hilo_r, hilo_nx_s;
    logic              stall_s;
`ifdef ALU_CTRL_DIV_EN
    logic              div_r, div_nx_s;
`endif

    alu_func_decode #(
        .FUNC_W (FUNC_W),
        .CTRL_W (CTRL_W)
    ) u_decode (
        .alu_op  (alu_op),
        .func    (func),
        .code    (dec_code_s),
        .is_mul  (dec_mul_s),
        .is_div  (dec_div_s),
        .illegal (dec_ill_s)
    );

    // The counter is loaded with LAT-2: the issue cycle and the final BUSY cycle bracket it
    assign mdu_op_s   = dec_mul_s | dec_div_s;
    assign cnt_init_s = dec_div_s ? CNT_W'(DIV_LAT - 2) : CNT_W'(MUL_LAT - 2);

    // Next-state, counter and next-output logic
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        code_nx_s  = code_r;
        cv_nx_s    = 1'b0;
        ill_nx_s   = 1'b0;
        start_nx_s = 1'b0;
        hilo_nx_s  = 1'b0;
        stall_s    = 1'b0;
`ifdef ALU_CTRL_DIV_EN
        div_nx_s   = div_r;
`endif
        case (state_r)
            IDLE: begin
                if (flush) begin
                    state_nx_s = IDLE;
                end else if (valid_in) begin
                    code_nx_s = dec_code_s;
                    cv_nx_s   = 1'b1;
                    ill_nx_s  = dec_ill_s;
                    if (mdu_op_s) begin
                        stall_s    = 1'b1;
                        start_nx_s = 1'b1;
                        cnt_nx_s   = cnt_init_s;
                        state_nx_s = BUSY;
`ifdef ALU_CTRL_DIV_EN
                        div_nx_s   = dec_div_s;
`endif
                    end else begin
                        state_nx_s = IDLE;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            BUSY: begin
                stall_s = 1'b1;
                if (flush) begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = {CNT_W{1'b0}};
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nx_s = DONE;
                    cv_nx_s    = 1'b1;
                    hilo_nx_s  = 1'b1;
                end else begin
                    cnt_nx_s = cnt_r - CNT_W'(1);
                end
            end
            DONE: begin
                // The stalled MULT/DIV is still in ID/EX here, so inputs are ignored
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state and latency counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_r  <= {CTRL_W{1'b0}};
            cv_r    <= 1'b0;
            ill_r   <= 1'b0;
            start_r <= 1'b0;
            hilo_r  <= 1'b0;
        end else begin
            code_r  <= code_nx_s;
            cv_r    <= cv_nx_s;
            ill_r   <= ill_nx_s;
            start_r <= start_nx_s;
            hilo_r  <= hilo_nx_s;
        end
    end

`ifdef ALU_CTRL_DIV_EN
    // MDU operation select, held from issue until the next issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= 1'b0;
        end else begin
            div_r <= div_nx_s;
        end
    end
    assign mdu_div = div_r;
`else
    assign mdu_div = 1'b0;
`endif

    assign alu_control = code_r;
    assign ctrl_valid  = cv_r;
    assign illegal     = ill_r;
    assign mdu_start   = start_r;
    // A flush arriving in the DONE cycle must still be able to squash the write
    assign hilo_we     = hilo_r & ~flush;
    assign stall       = stall_s & rst_n;

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Next-generation ALU control unit for the EX stage of the 32-bit RISC pipeline.
- Decodes alu_op/func into a registered ALU control word with a wider opcode set.
- Sequences multi-cycle MULT/DIV operations: counter-based busy FSM, pipeline stall request and HI/LO write strobe.
- Sits between the ID/EX register and the ALU/MDU; its stall output feeds the hazard/forwarding unit.

Parameters:
- FUNC_W, 6, width of R-type func field.
- CTRL_W, 4, width of alu_control output (must be >= 4).
- MUL_LAT, 4, MULT latency in cycles (>= 2).
- DIV_LAT, 16, DIV latency in cycles (>= 2).
- CNT_W, 5, latency counter width (must hold max(MUL_LAT, DIV_LAT) - 1).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  ID/EX holds a valid instruction this cycle
- alu_op  in  2  main-decoder ALU class: 0 add, 1 sub, 2 R-type, 3 add
- func  in  FUNC_W  R-type function field
- flush  in  1  squash EX-stage operation (branch/exception)
- alu_control  out  CTRL_W  registered ALU operation code
- ctrl_valid  out  1  alu_control valid this cycle
- illegal  out  1  registered; unknown func with alu_op=2
- mdu_start  out  1  one-cycle start pulse to MDU
- mdu_div  out  1  MDU op select: 1 = DIV, 0 = MULT; held while busy
- stall  out  1  combinational; freeze IF/ID/EX
- hilo_we  out  1  one-cycle HI/LO write strobe at completion

Behaviour:
- Reset (rst_n low, asynchronous): alu_control=0, ctrl_valid=0, illegal=0, mdu_start=0, mdu_div=0, hilo_we=0, state=IDLE, counter=0. stall=0 while in reset.
- Decode (combinational, registered on the next edge when valid_in and state=IDLE):
  - alu_op 0 -> 0 (ADD); 1 -> 1 (SUB); 3 -> 0.
  - alu_op 2, func: 100000->0, 100010->1, 100100->4, 100101->5, 100110->6 (XOR), 100111->7 (NOR), 101010->8 (SLT), 000000->9 (SLL), 000010->10 (SRL).
  - func 011000 -> MULT; 011010 -> DIV. Both multi-cycle; alu_control=0.
  - Any other func -> alu_control=0, illegal=1.
- Single-cycle latency: outputs update at edge N+1 for inputs at edge N. ctrl_valid mirrors valid_in registered.
- FSM states: IDLE, BUSY, DONE.
  - IDLE + valid_in + MULT/DIV: stall=1 combinationally in the same cycle. Next edge: state=BUSY, mdu_start=1 for one cycle, mdu_div set, counter=LAT-2.
  - BUSY: stall=1. Counter decrements each cycle. At counter=0, next state=DONE.
  - DONE: one cycle; hilo_we=1, stall=0, ctrl_valid=1. Next state=IDLE.
  - Total stall = LAT cycles from issue.
- While BUSY: valid_in/alu_op/func are ignored; alu_control holds its last value.
- flush has priority over everything except reset.
  - In IDLE: ctrl_valid, illegal and mdu_start cleared next edge; MULT/DIV not started; stall=0.
  - In BUSY: abort to IDLE next edge; no hilo_we; stall drops the cycle after flush.
  - In DONE: hilo_we suppressed.
- Back-to-back: a MULT/DIV presented in the DONE cycle is not accepted. It is re-presented because the pipeline advances the cycle after DONE.
- Reset mid-BUSY: immediate return to IDLE with all outputs cleared.

Optional Feature:
- Macro ALU_CTRL_DIV_EN.
- Defined: DIV decoded and sequenced with DIV_LAT as above.
- Undefined: func 011010 is treated as unknown (illegal=1, no stall, no mdu_start). mdu_div is tied to 0 and the DIV_LAT path is removed.

Decomposition:
- Package alu_ctrl_pkg:
  - ALU code constants: ALU_ADD=0, ALU_SUB=1, ALU_AND=4, ALU_OR=5, ALU_XOR=6, ALU_NOR=7, ALU_SLT=8, ALU_SLL=9, ALU_SRL=10.
  - func constants: F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLL, F_SRL, F_MULT, F_DIV.
  - alu_op encodings.
  - FSM state typedef (IDLE/BUSY/DONE).
- Sub-module alu_func_decode: purely combinational func/alu_op -> {code, is_mul, is_div, illegal}. The top holds the registers, counter and FSM.

Test Plan:
- Reset: rst_n=0 mid-BUSY -> all outputs 0 asynchronously, stall=0, state IDLE after release.
- Decode sweep: alu_op=2 with each legal func -> alu_control matches table one cycle later, ctrl_valid=1. func=111111 -> alu_control=0, illegal=1.
- MULT, MUL_LAT=4: valid_in with func=011000 -> stall high 4 cycles; mdu_start pulse at cycle 1, mdu_div=0; hilo_we=1 exactly in cycle 4.
- DIV, DIV_LAT=16, ALU_CTRL_DIV_EN defined: stall 16 cycles, mdu_div=1, single hilo_we. Macro undefined: illegal=1, no stall.
- Flush at BUSY cycle 2 of MULT -> stall low from cycle 3, no hilo_we, next ADD decoded normally.
- alu_op=0 then alu_op=1 on consecutive cycles -> alu_control 0 then 1, no stall.
